// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-and-add unsigned multiplier that borrows an
// external combinational ALU for every add and shift. One request at a time;
// the product is held on the response port until the consumer takes it.
module mul_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_product,
    output logic         resp_overflow,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result
);

    // Op codes understood by the shared team ALU.
    typedef enum logic [3:0] {
        ALU_NOP = 4'b0000,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_ADD = 4'b1000
    } alu_control_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        SHL,
        SHR,
        DONE
    } state_t;

    localparam logic [N-1:0] W_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_prod;
    logic [N-1:0] r_mcand;
    logic [N-1:0] r_mplr;
    logic         r_ovf;
    alu_control_t w_alu_op;

    assign alu_control = w_alu_op;

    // State register; reset abandons any operation in flight.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus all Moore outputs, including the ALU drive.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_product  = '0;
        resp_overflow = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        w_alu_op      = ALU_NOP;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next_state = CHECK;
            end
            CHECK: begin
                if (r_mplr == '0)   w_next_state = DONE;
                else if (r_mplr[0]) w_next_state = ADD;
                else                w_next_state = SHL;
            end
            ADD: begin
                alu_a        = r_prod;
                alu_b        = r_mcand;
                w_alu_op     = ALU_ADD;
                w_next_state = SHL;
            end
            SHL: begin
                alu_a        = r_mcand;
                alu_b        = W_ONE;
                w_alu_op     = ALU_SLL;
                w_next_state = SHR;
            end
            SHR: begin
                alu_a        = r_mplr;
                alu_b        = W_ONE;
                w_alu_op     = ALU_SRL;
                w_next_state = CHECK;
            end
            DONE: begin
                resp_valid    = 1'b1;
                resp_product  = r_prod;
                resp_overflow = r_ovf;
                if (resp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: load operands on acceptance, then fold ALU results back in.
    // Overflow is sticky: set by an add that wraps, or by losing the
    // multiplicand MSB while multiplier bits that still need it remain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_prod  <= '0;
                        r_mcand <= req_a;
                        r_mplr  <= req_b;
                        r_ovf   <= 1'b0;
                    end
                end
                ADD: begin
                    r_prod <= alu_result;
                    if (alu_result < r_prod) r_ovf <= 1'b1;
                end
                SHL: begin
                    r_mcand <= alu_result;
                    if (r_mcand[N-1] && (r_mplr[N-1:1] != '0)) r_ovf <= 1'b1;
                end
                SHR: begin
                    r_mplr <= alu_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: N, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_a  input  N  multiplicand, unsigned.
REQ-007 req_b  input  N  multiplier, unsigned.
REQ-008 resp_valid  output  1  product available.
REQ-009 resp_ready  input  1  consumer accepts product.
REQ-010 resp_product  output  N  low N bits of req_a*req_b.
REQ-011 resp_overflow  output  1  true product exceeded N bits.
REQ-012 alu_a, alu_b  output  N each  operands driven to the external ALU.
REQ-013 alu_control  output  4  ALU op code, team alu_control_t encoding.
REQ-014 alu_result  input  N  combinational ALU result for the current drive.

Function
REQ-015 Registers SHALL be: prod, mcand, mplr (N bits each), ovf (sticky), state.
REQ-016 States SHALL be IDLE, CHECK, ADD, SHL, SHR, DONE.
REQ-017 IDLE: req_ready=1; on req_valid&req_ready edge: prod<=0, mcand<=req_a, mplr<=req_b, ovf<=0, go CHECK.
REQ-018 CHECK: mplr==0 -> DONE; else mplr[0]==1 -> ADD; else -> SHL.
REQ-019 ADD: drive alu_a=prod, alu_b=mcand, alu_control=4'b1000 (ADD); prod<=alu_result; go SHL.
REQ-020 ADD: ovf<=1 if alu_result < prod (unsigned wrap), compared locally.
REQ-021 SHL: drive alu_a=mcand, alu_b=1, alu_control=4'b0101 (SLL); mcand<=alu_result; go SHR.
REQ-022 SHL: ovf<=1 if mcand[N-1]==1 and mplr[N-1:1]!=0.
REQ-023 SHR: drive alu_a=mplr, alu_b=1, alu_control=4'b0110 (SRL); mplr<=alu_result; go CHECK.
REQ-024 IDLE, CHECK, DONE: alu_a=0, alu_b=0, alu_control=4'b0000.
REQ-025 DONE: resp_valid=1, resp_product=prod, resp_overflow=ovf; all held stable until resp_ready; on resp_ready edge go IDLE.
REQ-026 resp_product/resp_overflow SHALL read 0 whenever resp_valid=0.
REQ-027 req_ready SHALL be 1 only in IDLE; requests outside IDLE are ignored (no queuing).
REQ-028 Latency, acceptance edge to resp_valid high: 3k+1+p cycles; k = index of highest set bit of req_b plus 1 (0 if req_b=0), p = popcount(req_b).
REQ-029 resp_ready in any state other than DONE SHALL have no effect.
REQ-030 Back-to-back: after DONE->IDLE, a new request is accepted no earlier than the following edge (one idle cycle minimum).
REQ-031 alu_result SHALL be sampled only in ADD, SHL, SHR; its value in other states is ignored.

Reset
REQ-032 rst high SHALL immediately force state=IDLE, prod=mcand=mplr=0, ovf=0, independent of clk.
REQ-033 During and after reset: req_ready=1, resp_valid=0, resp_product=0, resp_overflow=0, alu_a=alu_b=0, alu_control=4'b0000.
REQ-034 Reset mid-operation SHALL abandon the operation with no response emitted.

Verification (bench instantiates the team alu for the external ALU)
REQ-035 req_a=3, req_b=5 -> resp_valid 12 cycles after acceptance, resp_product=15, resp_overflow=0.
REQ-036 req_a=0x1234, req_b=0 -> resp_valid 1 cycle after acceptance, resp_product=0, resp_overflow=0; no ADD/SHL/SHR cycles seen on alu_control.
REQ-037 req_a=0x80000000, req_b=2 -> resp_product=0, resp_overflow=1; req_a=0xFFFFFFFF, req_b=1 -> resp_product=0xFFFFFFFF, resp_overflow=0.
REQ-038 resp_ready held low 20 cycles in DONE -> resp_valid/product stay stable, req_ready=0 throughout, second req_valid ignored; resp_ready pulse -> IDLE next edge.
REQ-039 rst asserted mid-way through req_a=7, req_b=0xFF -> all outputs zero asynchronously, no resp_valid; subsequent req_a=6, req_b=7 -> resp_product=42.
REQ-040 Random 1000 operand pairs -> resp_product == low 32 bits of a*b, resp_overflow == (a*b >= 2^32), latency per REQ-028.
